sdram_arbiter: RTL and testbench

Two-port arbiter that shares the single SDRAM controller port between the CPU memory path (MemoryUnit side) and a DMA requester (SPI-flash-to-SDRAM copy engine, later GPU fetch). It sits between those requesters and SDRAMcontroller. It serialises one word access at a time, uses fixed CPU priority, and has a starvation guard that guarantees DMA progress. Requester and controller handshakes are level-start / pulse-done.

---
 rtl/sdram_arbiter.sv | 102 ++++++++++
 tb/tb_sdram_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-port arbiter sharing one SDRAM controller port between the CPU path and a DMA engine.
// One word access at a time, fixed CPU priority, with a streak guard that bounds DMA starvation.
module sdram_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int MAX_CPU_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_start,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_done,
  input  logic              dma_start,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_data,
  output logic [DATA_W-1:0] dma_q,
  output logic              dma_done,
  output logic              sd_start,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_data,
  input  logic [DATA_W-1:0] sd_q,
  input  logic              sd_done,
  output logic              grant_dma
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);

  state_t     state;
  logic [3:0] streak;
  logic       pick_dma;

  // CPU wins ties unless it has already taken STREAK_MAX grants while DMA waited.
  assign pick_dma = dma_start && (!cpu_start || streak == STREAK_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      sd_start  <= 1'b0;
      sd_we     <= 1'b0;
      sd_addr   <= '0;
      sd_data   <= '0;
      cpu_q     <= '0;
      dma_q     <= '0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      grant_dma <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_start || dma_start) begin
            sd_start  <= 1'b1;
            grant_dma <= pick_dma;
            state     <= BUSY;
            if (pick_dma) begin
              sd_we   <= dma_we;
              sd_addr <= dma_addr;
              sd_data <= dma_data;
              streak  <= '0;
            end else begin
              sd_we   <= cpu_we;
              sd_addr <= cpu_addr;
              sd_data <= cpu_data;
              if (!dma_start)
                streak <= '0;
              else if (streak < STREAK_MAX)
                streak <= streak + 4'd1;
            end
          end
        end
        BUSY: begin
          if (sd_done) begin
            sd_start <= 1'b0;
            state    <= RELEASE;
            if (grant_dma) begin
              dma_q    <= sd_q;
              dma_done <= 1'b1;
            end else begin
              cpu_q    <= sd_q;
              cpu_done <= 1'b1;
            end
          end
        end
        RELEASE: begin
          // No grant here: the finished requester still has start high this cycle.
          cpu_done <= 1'b0;
          dma_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a fixed-latency SDRAM controller model.
module tb_sdram_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int LAT    = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_start = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_done;
  logic              dma_start = 1'b0, dma_we = 1'b0;
  logic [ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0] dma_data = '0;
  logic [DATA_W-1:0] dma_q;
  logic              dma_done;
  logic              sd_start, sd_we, sd_done, grant_dma;
  logic [ADDR_W-1:0] sd_addr;
  logic [DATA_W-1:0] sd_data, sd_q;

  logic              model_done, spur_done = 1'b0;
  logic [DATA_W-1:0] model_q;
  int                mcnt;

  int checks = 0, errors = 0;
  int cpu_pulses = 0, dma_pulses = 0, unstable = 0;
  logic prev_start = 1'b0;
  logic [ADDR_W+DATA_W:0] prev_cmd = '0;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_start(cpu_start), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_q(cpu_q), .cpu_done(cpu_done),
    .dma_start(dma_start), .dma_we(dma_we), .dma_addr(dma_addr), .dma_data(dma_data),
    .dma_q(dma_q), .dma_done(dma_done),
    .sd_start(sd_start), .sd_we(sd_we), .sd_addr(sd_addr), .sd_data(sd_data),
    .sd_q(sd_q), .sd_done(sd_done), .grant_dma(grant_dma)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] resp_for(input logic [ADDR_W-1:0] a);
    case (a)
      24'h000123: resp_for = 32'hDEADBEEF;
      24'h000200: resp_for = 32'hAAAA0001;
      24'h000300: resp_for = 32'hBBBB0002;
      default:    resp_for = 32'hC0DE0000 ^ {8'h00, a};
    endcase
  endfunction

  // Controller model: done pulse LAT cycles after it first sees sd_start.
  assign sd_done = model_done | spur_done;
  assign sd_q    = model_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_done <= 1'b0;
      model_q    <= '0;
      mcnt       <= 0;
    end else if (model_done) begin
      model_done <= 1'b0;
    end else if (sd_start) begin
      if (mcnt == LAT - 1) begin
        model_done <= 1'b1;
        model_q    <= resp_for(sd_addr);
        mcnt       <= 0;
      end else mcnt <= mcnt + 1;
    end else mcnt <= 0;
  end

  always @(negedge clk) begin
    if (cpu_done) cpu_pulses++;
    if (dma_done) dma_pulses++;
    if (sd_start && prev_start && {sd_we, sd_addr, sd_data} != prev_cmd) unstable++;
    prev_start = sd_start;
    prev_cmd   = {sd_we, sd_addr, sd_data};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int cyc);
    logic found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      found = sd_start;
    end
    chk("grant_timeout", 64'(found), 64'd1);
  endtask

  task automatic wait_done(output int cyc);
    logic found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      found = cpu_done | dma_done;
    end
    chk("done_timeout", 64'(found), 64'd1);
    chk("both_done", 64'(cpu_done & dma_done), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sd"}, {sd_start, sd_we, 6'd0, sd_addr, sd_data}, 64'd0);
    chk({tag, "_cpu_q"}, 64'(cpu_q), 64'd0);
    chk({tag, "_dma_q"}, 64'(dma_q), 64'd0);
    chk({tag, "_flags"}, 64'({cpu_done, dma_done, grant_dma}), 64'd0);
  endtask

  initial begin
    int gc, dc, c0, d0;
    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single CPU read
    c0 = cpu_pulses; d0 = dma_pulses;
    cpu_addr = 24'h000123; cpu_we = 1'b0; cpu_data = 32'h0; cpu_start = 1'b1;
    wait_grant(gc);
    chk("cpu_grant_lat", 64'(gc), 64'd1);
    chk("cpu_sd_addr", 64'(sd_addr), 64'h000123);
    chk("cpu_sd_we", 64'(sd_we), 64'd0);
    chk("cpu_grant_dma", 64'(grant_dma), 64'd0);
    wait_done(dc);
    chk("cpu_done_lat", 64'(dc), 64'd7);
    chk("cpu_done", 64'(cpu_done), 64'd1);
    chk("cpu_q", 64'(cpu_q), 64'hDEADBEEF);
    chk("cpu_sd_start_low", 64'(sd_start), 64'd0);
    cpu_start = 1'b0;
    @(negedge clk);
    chk("cpu_done_pulse", 64'(cpu_done), 64'd0);
    chk("cpu_pulse_count", 64'(cpu_pulses - c0), 64'd1);
    chk("cpu_no_dma_done", 64'(dma_pulses - d0), 64'd0);

    // Single DMA write; requester data changes mid-access must not leak through
    c0 = cpu_pulses; d0 = dma_pulses;
    dma_addr = 24'h7FFFFF; dma_data = 32'h12345678; dma_we = 1'b1; dma_start = 1'b1;
    wait_grant(gc);
    chk("dma_sd_we", 64'(sd_we), 64'd1);
    chk("dma_sd_addr", 64'(sd_addr), 64'h7FFFFF);
    chk("dma_sd_data", 64'(sd_data), 64'h12345678);
    chk("dma_grant", 64'(grant_dma), 64'd1);
    dma_data = 32'hFFFFFFFF; dma_addr = 24'h000001;
    wait_done(dc);
    chk("dma_done", 64'(dma_done), 64'd1);
    chk("dma_sd_data_held", 64'(sd_data), 64'h12345678);
    dma_start = 1'b0; dma_we = 1'b0;
    @(negedge clk);
    chk("dma_pulse_count", 64'(dma_pulses - d0), 64'd1);
    chk("dma_no_cpu_done", 64'(cpu_pulses - c0), 64'd0);
    chk("dma_grant_sticky", 64'(grant_dma), 64'd1);

    // Simultaneous first request, streak at 0: CPU first, then DMA
    @(negedge clk);
    cpu_addr = 24'h000200; cpu_we = 1'b0; cpu_start = 1'b1;
    dma_addr = 24'h000300; dma_we = 1'b0; dma_start = 1'b1;
    wait_grant(gc);
    chk("sim_first_cpu", 64'(grant_dma), 64'd0);
    chk("sim_cpu_addr", 64'(sd_addr), 64'h000200);
    wait_done(dc);
    chk("sim_cpu_q", 64'(cpu_q), 64'hAAAA0001);
    cpu_start = 1'b0;
    wait_grant(gc);
    chk("sim_dma_next_lat", 64'(gc), 64'd2);
    chk("sim_then_dma", 64'(grant_dma), 64'd1);
    chk("sim_dma_addr", 64'(sd_addr), 64'h000300);
    wait_done(dc);
    chk("sim_dma_q", 64'(dma_q), 64'hBBBB0002);
    chk("sim_cpu_q_held", 64'(cpu_q), 64'hAAAA0001);
    dma_start = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: both held high, expect C,C,C,C,D repeating
    cpu_addr = 24'h000010; dma_addr = 24'h000020;
    cpu_start = 1'b1; dma_start = 1'b1;
    for (int n = 0; n < 10; n++) begin
      wait_grant(gc);
      chk($sformatf("streak_grant_%0d", n), 64'(grant_dma), 64'((n % 5) == 4));
      wait_done(dc);
    end
    cpu_start = 1'b0; dma_start = 1'b0;
    repeat (3) @(negedge clk);

    // Spurious sd_done while idle
    c0 = cpu_pulses; d0 = dma_pulses;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_sd_start", 64'(sd_start), 64'd0);
    chk("spur_no_done", 64'((cpu_pulses - c0) + (dma_pulses - d0)), 64'd0);

    // Reset in BUSY, then a clean CPU read
    cpu_addr = 24'h000456; cpu_we = 1'b0; cpu_start = 1'b1;
    wait_grant(gc);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cpu_start = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    c0 = cpu_pulses; d0 = dma_pulses;
    repeat (10) @(negedge clk);
    chk("no_stale_done", 64'((cpu_pulses - c0) + (dma_pulses - d0)), 64'd0);
    cpu_addr = 24'h000123; cpu_start = 1'b1;
    wait_grant(gc);
    chk("post_reset_lat", 64'(gc), 64'd1);
    wait_done(dc);
    chk("post_reset_done_lat", 64'(dc), 64'd7);
    chk("post_reset_cpu_q", 64'(cpu_q), 64'hDEADBEEF);
    cpu_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_pulses", 64'(cpu_pulses - c0), 64'd1);
    chk("sd_cmd_stable", 64'(unstable), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
